ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameters (name, default, meaning) SHALL be:
  INSTR_W, 9, instruction width; opcode in [INSTR_W-1:INSTR_W-3], function field in [5:4].
  PA_W, 3, register-pointer width; minimum 2.
  MEM_LAT, 1, cycles a LW/SW holds its controls; legal range 1..15.
REQ-003 Ports (name direction width meaning) SHALL be:
  clk  input  1  clock.
  rst_n  input  1  synchronous active-low reset.
  instr_valid  input  1  instr holds a valid instruction.
  instr  input  INSTR_W  instruction word.
  instr_ready  output  1  block accepts instr this cycle.
  ctrl_valid  output  1  control outputs describe an accepted instruction.
  read0_pa, read1_pa, write_pa  output  PA_W each  persistent register pointers.
  reg_imm, reg_write_src, mem_write, mem_read, reg_write, reg_read_write, reg_write_read  output  1 each  datapath controls.
  alu_op  output  4  ALU operation.
  alu_src  output  2  ALU operand select.

Function
REQ-004 An instruction SHALL be accepted on any rising edge where instr_valid and instr_ready are both 1.
REQ-005 All control outputs SHALL be registered; an instruction accepted in cycle N SHALL drive them from cycle N+1.
REQ-006 Decode SHALL be:
  REG: reg_write=1, alu_src=01, alu_op=SLB.
  ARITH/SHIFT: reg_imm, reg_read_write, reg_write_read and reg_write =1; alu_op=ADD/SUB or SHIFTL/SHIFTR when instr[5]=0/1.
  SLT/XOR/AND/OR: reg_write_read=1, reg_write=1, alu_src=10, alu_op=matching ALU code.
  HARD/LW: reg_read_write, mem_read, reg_write_src =1; reg_write per REQ-010.
  HARD/SW: reg_write_read=1, mem_write=1.
  HARD/BRANCH: reg_write_read=1, alu_op=BNZ, alu_src=10.
  Any output not listed SHALL be 0.
REQ-007 HARD/REDEF SHALL drive all controls to 0, assert ctrl_valid, and load instr[1:0], zero-extended to PA_W, into read0_pa/read1_pa/write_pa when instr[3:2]=00/01/10; 11 SHALL be a NOP.
REQ-008 Pointer registers SHALL hold their value between REDEFs; a new value SHALL be visible from N+1.
REQ-009 The FSM SHALL have two states:
  RUN: instr_ready=1. Accepting LW/SW with MEM_LAT>1 SHALL go to MEM_WAIT with count=MEM_LAT-1; otherwise stay in RUN.
  MEM_WAIT: instr_ready=0; control registers hold; count decrements each cycle; at count=1 SHALL return to RUN.
REQ-010 A LW/SW control set SHALL be visible for exactly MEM_LAT cycles (N+1..N+MEM_LAT); instr_ready SHALL be 0 for N+1..N+MEM_LAT-1; LW reg_write SHALL be 1 only in cycle N+MEM_LAT.
REQ-011 In RUN with no acceptance, the next cycle SHALL have ctrl_valid=0 and all controls 0, with pointers holding.
REQ-012 Back-to-back acceptances SHALL produce back-to-back control sets with no bubble.
REQ-013 instr_valid SHALL be ignored in MEM_WAIT and during reset.

Reset
REQ-014 With rst_n=0 at a rising edge, the FSM SHALL enter RUN; ctrl_valid, all controls and all pointers SHALL be 0; any MEM_WAIT in progress SHALL be abandoned.
REQ-015 instr_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.

Structure
REQ-016 Shared package roe_pkg SHALL hold:
  op_code: REG=0, ARITH=1, SHIFT=2, HARD=3, SLT=4, XOR=5, AND=6, OR=7.
  func_code: REDEF=0, LW=1, SW=2, BRANCH=3.
  alu codes: ADD=0, SUB=1, SHIFTL=2, SHIFTR=3, SLB=4, BNZ=5, ALU_SLT=6, ALU_XOR=7, ALU_AND=8, ALU_OR=9.
  REDEF selector codes.
REQ-017 Decode SHALL be a combinational sub-module ctrl_decode; ctrl_seq SHALL hold the FSM, counter, pointer registers and output registers.
REQ-018 An elaboration-time check SHALL reject MEM_LAT outside 1..15 and PA_W<2.

Verification
REQ-019 The bench SHALL cover these scenarios:
  Reset: rst_n=0 for 2 cycles with instr_valid=1 -> all outputs and pointers 0; instr_ready=1 after release.
  ARITH: 9'h040 accepted at N -> at N+1, reg_imm, reg_read_write, reg_write_read, reg_write =1, alu_op=0, ctrl_valid=1; instr_valid=0 -> N+2 all 0.
  REDEF: 9'h0C7 -> read1_pa=3 from N+1 and held; then 9'h0CC (NOP) -> read1_pa and write_pa unchanged.
  LW, MEM_LAT=3: 9'h0D0 at N -> mem_read=1 for N+1..N+3; reg_write=1 only at N+3; instr_ready=0 for N+1..N+2; 9'h1C0 accepted at N+3 -> alu_op=9, alu_src=10 at N+4.
  Reset mid-LW, MEM_LAT=3: rst_n=0 at N+2 -> N+3 all 0, instr_ready=1 after release, pointers 0.
  SW then OR, MEM_LAT=1: 9'h0E0 at N, 9'h1C0 at N+1 -> mem_write=1 only at N+1; alu_op=9 at N+2; instr_ready constantly 1.

Source files
------------

// File: rtl/roe_pkg.sv
// Shared encodings for the control sequencer: opcodes, HARD function codes,
// ALU operations, REDEF pointer selectors and the registered control bundle.
package roe_pkg;

  typedef enum logic [2:0] {
    OP_REG   = 3'd0,
    OP_ARITH = 3'd1,
    OP_SHIFT = 3'd2,
    OP_HARD  = 3'd3,
    OP_SLT   = 3'd4,
    OP_XOR   = 3'd5,
    OP_AND   = 3'd6,
    OP_OR    = 3'd7
  } op_code_t;

  typedef enum logic [1:0] {
    FN_REDEF  = 2'd0,
    FN_LW     = 2'd1,
    FN_SW     = 2'd2,
    FN_BRANCH = 2'd3
  } func_code_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SHIFTL = 4'd2,
    ALU_SHIFTR = 4'd3,
    ALU_SLB    = 4'd4,
    ALU_BNZ    = 4'd5,
    ALU_SLT    = 4'd6,
    ALU_XOR    = 4'd7,
    ALU_AND    = 4'd8,
    ALU_OR     = 4'd9
  } alu_code_t;

  typedef enum logic [1:0] {
    SEL_READ0 = 2'd0,
    SEL_READ1 = 2'd1,
    SEL_WRITE = 2'd2,
    SEL_NOP   = 2'd3
  } redef_sel_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_SLB  = 2'b01;
  localparam logic [1:0] SRC_RR   = 2'b10;

  typedef struct packed {
    logic       reg_imm;
    logic       reg_write_src;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       reg_read_write;
    logic       reg_write_read;
    alu_code_t  alu_op;
    logic [1:0] alu_src;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder. LW leaves reg_write at 0; the sequencer
// raises it in the last cycle of the memory access.
module ctrl_decode
  import roe_pkg::*;
#(
  parameter int INSTR_W = 9
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic               is_mem,
  output logic               is_lw,
  output logic               redef_en,
  output redef_sel_t         redef_sel
);

  op_code_t   op;
  func_code_t fn;

  assign op = op_code_t'(instr[INSTR_W-1 -: 3]);
  assign fn = func_code_t'(instr[5:4]);

  always_comb begin
    ctrl      = '0;
    is_mem    = 1'b0;
    is_lw     = 1'b0;
    redef_en  = 1'b0;
    redef_sel = redef_sel_t'(instr[3:2]);
    case (op)
      OP_REG: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = SRC_SLB;
        ctrl.alu_op    = ALU_SLB;
      end
      OP_ARITH, OP_SHIFT: begin
        ctrl.reg_imm        = 1'b1;
        ctrl.reg_read_write = 1'b1;
        ctrl.reg_write_read = 1'b1;
        ctrl.reg_write      = 1'b1;
        if (op == OP_ARITH) ctrl.alu_op = instr[5] ? ALU_SUB : ALU_ADD;
        else                ctrl.alu_op = instr[5] ? ALU_SHIFTR : ALU_SHIFTL;
      end
      OP_HARD: begin
        case (fn)
          FN_REDEF: redef_en = (instr[3:2] != SEL_NOP);
          FN_LW: begin
            ctrl.reg_read_write = 1'b1;
            ctrl.mem_read       = 1'b1;
            ctrl.reg_write_src  = 1'b1;
            is_mem              = 1'b1;
            is_lw               = 1'b1;
          end
          FN_SW: begin
            ctrl.reg_write_read = 1'b1;
            ctrl.mem_write      = 1'b1;
            is_mem              = 1'b1;
          end
          default: begin
            ctrl.reg_write_read = 1'b1;
            ctrl.alu_op         = ALU_BNZ;
            ctrl.alu_src        = SRC_RR;
          end
        endcase
      end
      default: begin
        ctrl.reg_write_read = 1'b1;
        ctrl.reg_write      = 1'b1;
        ctrl.alu_src        = SRC_RR;
        case (op)
          OP_SLT:  ctrl.alu_op = ALU_SLT;
          OP_XOR:  ctrl.alu_op = ALU_XOR;
          OP_AND:  ctrl.alu_op = ALU_AND;
          default: ctrl.alu_op = ALU_OR;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: registers decoded controls, holds LW/SW control sets for
// MEM_LAT cycles, and keeps the REDEF-loaded register pointers.
module ctrl_seq
  import roe_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int PA_W    = 3,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               ctrl_valid,
  output logic [PA_W-1:0]    read0_pa,
  output logic [PA_W-1:0]    read1_pa,
  output logic [PA_W-1:0]    write_pa,
  output logic               reg_imm,
  output logic               reg_write_src,
  output logic               mem_write,
  output logic               mem_read,
  output logic               reg_write,
  output logic               reg_read_write,
  output logic               reg_write_read,
  output logic [3:0]         alu_op,
  output logic [1:0]         alu_src
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || PA_W < 2 || INSTR_W < 9) begin : g_bad_param
    $error("ctrl_seq: illegal parameters MEM_LAT=%0d PA_W=%0d INSTR_W=%0d", MEM_LAT, PA_W, INSTR_W);
  end

  localparam logic [3:0] WAIT_CNT   = 4'(MEM_LAT - 1);
  localparam bit         SINGLE_LAT = (MEM_LAT == 1);

  state_t                state_reg, state_next;
  logic [3:0]            count_reg, count_next;
  ctrl_t                 ctrl_reg, ctrl_next;
  logic                  valid_reg, valid_next;
  logic [2:0][PA_W-1:0]  ptr_reg, ptr_next;

  ctrl_t      dec_ctrl;
  logic       dec_mem, dec_lw, dec_redef;
  redef_sel_t dec_sel;
  logic       accept;

  ctrl_decode #(.INSTR_W(INSTR_W)) u_decode (
    .instr     (instr),
    .ctrl      (dec_ctrl),
    .is_mem    (dec_mem),
    .is_lw     (dec_lw),
    .redef_en  (dec_redef),
    .redef_sel (dec_sel)
  );

  assign instr_ready = rst_n & (state_reg == ST_RUN);
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ctrl_next  = ctrl_reg;
    valid_next = valid_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_RUN: begin
        if (accept) begin
          ctrl_next  = dec_ctrl;
          valid_next = 1'b1;
          if (dec_lw && SINGLE_LAT) ctrl_next.reg_write = 1'b1;
          if (dec_mem && !SINGLE_LAT) begin
            state_next = ST_MEM_WAIT;
            count_next = WAIT_CNT;
          end
          for (int i = 0; i < 3; i++) begin
            if (dec_redef && int'(dec_sel) == i) ptr_next[i] = PA_W'(instr[1:0]);
          end
        end else begin
          ctrl_next  = '0;
          valid_next = 1'b0;
        end
      end
      default: begin
        // The control set stays frozen; only the LW write-back strobe appears at the end.
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) begin
          state_next = ST_RUN;
          if (ctrl_reg.mem_read) ctrl_next.reg_write = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      count_reg <= '0;
      ctrl_reg  <= '0;
      valid_reg <= 1'b0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ctrl_reg  <= ctrl_next;
      valid_reg <= valid_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign ctrl_valid     = valid_reg;
  assign read0_pa       = ptr_reg[0];
  assign read1_pa       = ptr_reg[1];
  assign write_pa       = ptr_reg[2];
  assign reg_imm        = ctrl_reg.reg_imm;
  assign reg_write_src  = ctrl_reg.reg_write_src;
  assign mem_write      = ctrl_reg.mem_write;
  assign mem_read       = ctrl_reg.mem_read;
  assign reg_write      = ctrl_reg.reg_write;
  assign reg_read_write = ctrl_reg.reg_read_write;
  assign reg_write_read = ctrl_reg.reg_write_read;
  assign alu_op         = ctrl_reg.alu_op;
  assign alu_src        = ctrl_reg.alu_src;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus and are
// compared every cycle against a per-instance reference model plus table/hand checks.
module tb_ctrl_seq;

  typedef struct packed {
    logic       cv;
    logic [2:0] r0;
    logic [2:0] r1;
    logic [2:0] wp;
    logic       imm;
    logic       wsrc;
    logic       mw;
    logic       mr;
    logic       rw;
    logic       rrw;
    logic       rwr;
    logic [3:0] alu;
    logic [1:0] src;
    logic       rdy;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       v;
    logic [8:0] ins;
    logic       cv;
    logic [3:0] alu;
    logic [1:0] src;
    logic       imm;
    logic       mr;
    logic       rw;
    logic       rdy;
    logic [2:0] r1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [8:0] instr = '0;

  logic       rdy_a, cv_a, imm_a, wsrc_a, mw_a, mr_a, rw_a, rrw_a, rwr_a;
  logic [2:0] r0_a, r1_a, wp_a;
  logic [3:0] alu_a;
  logic [1:0] src_a;
  logic       rdy_b, cv_b, imm_b, wsrc_b, mw_b, mr_b, rw_b, rrw_b, rwr_b;
  logic [2:0] r0_b, r1_b, wp_b;
  logic [3:0] alu_b;
  logic [1:0] src_b;

  obs_t obs_l1, obs_l3;
  obs_t m_o [2];
  int   m_hold [2] = '{0, 0};
  int   lat [2] = '{1, 3};
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  vec_t tbl [13];

  always #5 clk = ~clk;

  ctrl_seq #(.INSTR_W(9), .PA_W(3), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(rdy_a), .ctrl_valid(cv_a), .read0_pa(r0_a), .read1_pa(r1_a), .write_pa(wp_a),
    .reg_imm(imm_a), .reg_write_src(wsrc_a), .mem_write(mw_a), .mem_read(mr_a), .reg_write(rw_a),
    .reg_read_write(rrw_a), .reg_write_read(rwr_a), .alu_op(alu_a), .alu_src(src_a)
  );

  ctrl_seq #(.INSTR_W(9), .PA_W(3), .MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(rdy_b), .ctrl_valid(cv_b), .read0_pa(r0_b), .read1_pa(r1_b), .write_pa(wp_b),
    .reg_imm(imm_b), .reg_write_src(wsrc_b), .mem_write(mw_b), .mem_read(mr_b), .reg_write(rw_b),
    .reg_read_write(rrw_b), .reg_write_read(rwr_b), .alu_op(alu_b), .alu_src(src_b)
  );

  assign obs_l1 = {cv_a, r0_a, r1_a, wp_a, imm_a, wsrc_a, mw_a, mr_a, rw_a, rrw_a, rwr_a, alu_a, src_a, rdy_a};
  assign obs_l3 = {cv_b, r0_b, r1_b, wp_b, imm_b, wsrc_b, mw_b, mr_b, rw_b, rrw_b, rwr_b, alu_b, src_b, rdy_b};

  // Decode table written straight from the instruction set description.
  function automatic obs_t decode_ref(logic [8:0] ins);
    obs_t o;
    logic [2:0] op;
    logic [1:0] fn;
    o  = '0;
    op = ins[8:6];
    fn = ins[5:4];
    if (op == 3'd0) begin
      o.rw = 1'b1; o.src = 2'b01; o.alu = 4'd4;
    end else if (op == 3'd1 || op == 3'd2) begin
      o.imm = 1'b1; o.rrw = 1'b1; o.rwr = 1'b1; o.rw = 1'b1;
      o.alu = (op == 3'd1) ? (ins[5] ? 4'd1 : 4'd0) : (ins[5] ? 4'd3 : 4'd2);
    end else if (op == 3'd3) begin
      if (fn == 2'd1) begin o.rrw = 1'b1; o.mr = 1'b1; o.wsrc = 1'b1; end
      if (fn == 2'd2) begin o.rwr = 1'b1; o.mw = 1'b1; end
      if (fn == 2'd3) begin o.rwr = 1'b1; o.alu = 4'd5; o.src = 2'b10; end
    end else begin
      o.rwr = 1'b1; o.rw = 1'b1; o.src = 2'b10;
      o.alu = 4'd6 + {1'b0, op} - 4'd4;
    end
    return o;
  endfunction

  task automatic model_step(int d, logic rst, logic v, logic [8:0] ins);
    obs_t o;
    logic [2:0] p0, p1, p2;
    o  = m_o[d];
    p0 = o.r0; p1 = o.r1; p2 = o.wp;
    if (!rst) begin
      o = '0;
      m_hold[d] = 0;
    end else if (m_hold[d] > 0) begin
      m_hold[d] = m_hold[d] - 1;
      if (m_hold[d] == 0 && o.mr) o.rw = 1'b1;
    end else if (v) begin
      o = decode_ref(ins);
      o.cv = 1'b1;
      if (ins[8:6] == 3'd3 && ins[5:4] == 2'd0) begin
        if (ins[3:2] == 2'd0) p0 = {1'b0, ins[1:0]};
        if (ins[3:2] == 2'd1) p1 = {1'b0, ins[1:0]};
        if (ins[3:2] == 2'd2) p2 = {1'b0, ins[1:0]};
      end
      if (ins[8:6] == 3'd3 && (ins[5:4] == 2'd1 || ins[5:4] == 2'd2)) begin
        m_hold[d] = lat[d] - 1;
        if (ins[5:4] == 2'd1 && lat[d] == 1) o.rw = 1'b1;
      end
      o.r0 = p0; o.r1 = p1; o.wp = p2;
    end else begin
      o = '0;
      o.r0 = p0; o.r1 = p1; o.wp = p2;
    end
    o.rdy = rst && (m_hold[d] == 0);
    m_o[d] = o;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(logic rst, logic v, logic [8:0] ins);
    rst_n = rst; instr_valid = v; instr = ins;
    @(posedge clk);
    model_step(0, rst, v, ins);
    model_step(1, rst, v, ins);
    #1;
    cyc++;
    $display("cyc=%0d rst_n=%b v=%b instr=%h l1=%h l3=%h", cyc, rst, v, ins, obs_l1, obs_l3);
    chk("model_l1", 32'(obs_l1), 32'(m_o[0]));
    chk("model_l3", 32'(obs_l3), 32'(m_o[1]));
  endtask

  initial begin
    // rst, v, instr, cv, alu, src, imm, mr, rw, rdy, read1 -- expectations for MEM_LAT=3
    tbl[0]  = '{1'b0, 1'b1, 9'h0D0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b1, 9'h0D0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 9'h000, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[3]  = '{1'b1, 1'b1, 9'h040, 1'b1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[4]  = '{1'b1, 1'b0, 9'h000, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[5]  = '{1'b1, 1'b1, 9'h0C7, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
    tbl[6]  = '{1'b1, 1'b1, 9'h0CC, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
    tbl[7]  = '{1'b1, 1'b0, 9'h000, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
    tbl[8]  = '{1'b1, 1'b1, 9'h0D0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[9]  = '{1'b1, 1'b1, 9'h1C0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[10] = '{1'b1, 1'b1, 9'h1C0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3};
    tbl[11] = '{1'b1, 1'b1, 9'h1C0, 1'b1, 4'd9, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3};
    tbl[12] = '{1'b1, 1'b0, 9'h000, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].ins);
      chk("tbl_ctrl_valid", 32'(cv_b), 32'(tbl[i].cv));
      chk("tbl_alu_op", 32'(alu_b), 32'(tbl[i].alu));
      chk("tbl_alu_src", 32'(src_b), 32'(tbl[i].src));
      chk("tbl_reg_imm", 32'(imm_b), 32'(tbl[i].imm));
      chk("tbl_mem_read", 32'(mr_b), 32'(tbl[i].mr));
      chk("tbl_reg_write", 32'(rw_b), 32'(tbl[i].rw));
      chk("tbl_instr_ready", 32'(rdy_b), 32'(tbl[i].rdy));
      chk("tbl_read1_pa", 32'(r1_b), 32'(tbl[i].r1));
    end
    chk("redef_write_pa_held", 32'(wp_b), 32'd0);

    // Reset in the middle of a MEM_LAT=3 load abandons it and clears the pointers.
    cycle(1'b1, 1'b1, 9'h0D0);
    chk("midlw_mem_read_n1", 32'(mr_b), 32'd1);
    cycle(1'b1, 1'b0, 9'h000);
    chk("midlw_ready_n2", 32'(rdy_b), 32'd0);
    cycle(1'b0, 1'b1, 9'h040);
    chk("midlw_rst_mem_read", 32'(mr_b), 32'd0);
    chk("midlw_rst_valid", 32'(cv_b), 32'd0);
    chk("midlw_rst_ready", 32'(rdy_b), 32'd0);
    cycle(1'b1, 1'b0, 9'h000);
    chk("midlw_release_ready", 32'(rdy_b), 32'd1);
    chk("midlw_read1_cleared", 32'(r1_b), 32'd0);

    // SW then OR back to back with MEM_LAT=1.
    cycle(1'b1, 1'b1, 9'h0E0);
    chk("sw_mem_write_n1", 32'(mw_a), 32'd1);
    chk("sw_ready_n1", 32'(rdy_a), 32'd1);
    cycle(1'b1, 1'b1, 9'h1C0);
    chk("or_mem_write_n2", 32'(mw_a), 32'd0);
    chk("or_alu_op_n2", 32'(alu_a), 32'd9);
    chk("or_alu_src_n2", 32'(src_a), 32'd2);
    chk("or_ready_n2", 32'(rdy_a), 32'd1);
    cycle(1'b1, 1'b0, 9'h000);
    chk("idle_after_or", 32'(cv_a), 32'd0);

    // Random traffic against the reference model; occasional resets and heavy HARD mix.
    for (int i = 0; i < 600; i++) begin
      logic       r, v;
      logic [8:0] ins;
      r   = ($urandom_range(0, 39) != 0);
      v   = ($urandom_range(0, 9) < 7);
      ins = 9'($urandom);
      if ($urandom_range(0, 2) == 0) ins[8:6] = 3'd3;
      cycle(r, v, ins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
